// File: rtl/regfile_sb.sv
// Two-write/two-read register file with write-through bypass and a pending-write scoreboard.
// Latency: reads and hazard flags are combinational; storage, busy bits and pending update at the rising edge.
// Backpressure: none; every write, issue and flush is accepted in the cycle it is presented.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
    output logic              hazard1,
    output logic              hazard2,
    output logic [ADDR_W:0]   pending
);

    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   pending_nxt;

    // Legal write/issue qualifiers: register 0 is inert when ZERO_REG is set.
    logic we0;
    logic we1;
    logic set_en;
    logic rd1_zero;
    logic rd2_zero;

    assign we0      = wr0 & ~(ZR & (waddr0 == '0));
    assign we1      = wr1 & ~(ZR & (waddr1 == '0));
    assign set_en   = issue & ~(ZR & (issue_addr == '0));
    assign rd1_zero = ZR & (raddr1 == '0);
    assign rd2_zero = ZR & (raddr2 == '0);

    // Storage update; on an address collision the load port (1) wins. Under ZERO_REG
    // entry 0 is never written, so its flop stays at its reset value and is trimmed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we1 && (waddr1 == ADDR_W'(i))) begin
                    mem[i] <= wdata1;
                end else if (we0 && (waddr0 == ADDR_W'(i))) begin
                    mem[i] <= wdata0;
                end
            end
        end
    end

    // Read port 1: zero register, then load bypass, then ALU bypass, then storage.
    always_comb begin
        rdata1 = mem[raddr1];
        if (rd1_zero) begin
            rdata1 = '0;
        end else if (we1 && (waddr1 == raddr1)) begin
            rdata1 = wdata1;
        end else if (we0 && (waddr0 == raddr1)) begin
            rdata1 = wdata0;
        end
    end

    // Read port 2: same priority as read port 1.
    always_comb begin
        rdata2 = mem[raddr2];
        if (rd2_zero) begin
            rdata2 = '0;
        end else if (we1 && (waddr1 == raddr2)) begin
            rdata2 = wdata1;
        end else if (we0 && (waddr0 == raddr2)) begin
            rdata2 = wdata0;
        end
    end

    // Next busy vector: writebacks clear, a new issue re-sets (new producer wins), flush clears all.
    always_comb begin
        busy_nxt = busy;
        if (we0) begin
            busy_nxt[waddr0] = 1'b0;
        end
        if (we1) begin
            busy_nxt[waddr1] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[issue_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
    end

    // Net change of the busy popcount. A clear only counts if the bit was set and is
    // not re-set by an issue in the same cycle; two ports clearing one address count once.
    logic add_one;
    logic sub0;
    logic sub1;

    assign add_one = set_en & ~busy[issue_addr];
    assign sub0    = we0 & busy[waddr0] & ~(set_en & (issue_addr == waddr0));
    assign sub1    = we1 & busy[waddr1] & ~(set_en & (issue_addr == waddr1))
                   & ~(we0 & (waddr0 == waddr1));

    // Pending counter next value: zero on flush, otherwise the running count plus the delta.
    always_comb begin
        pending_nxt = pending
                    + {{ADDR_W{1'b0}}, add_one}
                    - {{ADDR_W{1'b0}}, sub0}
                    - {{ADDR_W{1'b0}}, sub1};
        if (flush) begin
            pending_nxt = '0;
        end
    end

    // Scoreboard state; a reset discards any outstanding producers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= '0;
            pending <= '0;
        end else begin
            busy    <= busy_nxt;
            pending <= pending_nxt;
        end
    end

    // Hazard flags: busy and not being satisfied by a writeback this very cycle.
    logic hit1;
    logic hit2;

    assign hit1    = (we0 & (waddr0 == raddr1)) | (we1 & (waddr1 == raddr1));
    assign hit2    = (we0 & (waddr0 == raddr2)) | (we1 & (waddr1 == raddr2));
    assign hazard1 = busy[raddr1] & ~hit1 & ~rd1_zero;
    assign hazard2 = busy[raddr2] & ~hit2 & ~rd2_zero;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a cycle-tagged expectation queue and an independent monitor.
// Expected values are hand-computed and pushed as each cycle's stimulus is applied.
// The monitor compares on the falling edge, away from the active clock edge.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam int K_RD1  = 0;
    localparam int K_RD2  = 1;
    localparam int K_HZ1  = 2;
    localparam int K_HZ2  = 3;
    localparam int K_PEND = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr0 = 1'b0;
    logic [AW-1:0] waddr0 = '0;
    logic [DW-1:0] wdata0 = '0;
    logic          wr1 = 1'b0;
    logic [AW-1:0] waddr1 = '0;
    logic [DW-1:0] wdata1 = '0;
    logic [AW-1:0] raddr1 = '0;
    logic [AW-1:0] raddr2 = '0;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          issue = 1'b0;
    logic [AW-1:0] issue_addr = '0;
    logic          flush = 1'b0;
    logic          hazard1;
    logic          hazard2;
    logic [AW:0]   pending;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .wr0        (wr0),
        .waddr0     (waddr0),
        .wdata0     (wdata0),
        .wr1        (wr1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .issue      (issue),
        .issue_addr (issue_addr),
        .flush      (flush),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_val(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        wr0   = 1'b0;
        wr1   = 1'b0;
        issue = 1'b0;
        flush = 1'b0;
    endtask

    // Monitor: pop every expectation tagged for the current cycle and compare.
    always @(negedge clk) begin
        logic [31:0] act;
        exp_t        e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_tests++;
            case (e.kind)
                K_RD1:   act = rdata1;
                K_RD2:   act = rdata2;
                K_HZ1:   act = {31'b0, hazard1};
                K_HZ2:   act = {31'b0, hazard2};
                default: act = 32'(pending);
            endcase
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: stale expectation from cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", e.name, cyc, act, e.val);
            end
        end
    end

    initial begin
        // Reset held low: scoreboard and outputs idle.
        raddr1 = 5'd3;
        raddr2 = 5'd4;
        tick();
        expect_val(K_PEND, 0, "in_reset_pending");
        expect_val(K_RD1, 0, "in_reset_rd1");
        expect_val(K_HZ1, 0, "in_reset_hz1");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Every address reads zero after reset.
        for (int a = 0; a < 32; a++) begin
            tick();
            raddr1 = AW'(a);
            raddr2 = AW'(31 - a);
            expect_val(K_RD1, 0, "reset_rd1");
            expect_val(K_RD2, 0, "reset_rd2");
            expect_val(K_HZ1, 0, "reset_hz1");
            expect_val(K_HZ2, 0, "reset_hz2");
            expect_val(K_PEND, 0, "reset_pending");
        end

        // Write collision on 7: load port wins, both in bypass and in storage.
        tick();
        wr0 = 1; waddr0 = 5'd7; wdata0 = 32'h11;
        wr1 = 1; waddr1 = 5'd7; wdata1 = 32'h22;
        raddr1 = 5'd7; raddr2 = 5'd7;
        expect_val(K_RD1, 32'h22, "collide_bypass_rd1");
        expect_val(K_RD2, 32'h22, "collide_bypass_rd2");
        tick();
        expect_val(K_RD1, 32'h22, "collide_stored");
        expect_val(K_PEND, 0, "clear_idle_pending");

        // ALU-port bypass alone, then from storage.
        tick();
        wr0 = 1; waddr0 = 5'd10; wdata0 = 32'h55;
        raddr2 = 5'd10;
        expect_val(K_RD2, 32'h55, "wr0_bypass");
        expect_val(K_RD1, 32'h22, "unrelated_rd1");
        tick();
        expect_val(K_RD2, 32'h55, "wr0_stored");

        // Two ports, different addresses, same edge.
        tick();
        wr0 = 1; waddr0 = 5'd11; wdata0 = 32'h0B;
        wr1 = 1; waddr1 = 5'd12; wdata1 = 32'h0C;
        tick();
        raddr1 = 5'd11; raddr2 = 5'd12;
        expect_val(K_RD1, 32'h0B, "dual_wr_rd1");
        expect_val(K_RD2, 32'h0C, "dual_wr_rd2");

        // Zero register ignores writes and issues.
        tick();
        wr0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        issue = 1; issue_addr = 5'd0;
        raddr1 = 5'd0;
        expect_val(K_RD1, 0, "zero_bypass");
        expect_val(K_HZ1, 0, "zero_hz_same");
        tick();
        expect_val(K_RD1, 0, "zero_stored");
        expect_val(K_HZ1, 0, "zero_hz_next");
        expect_val(K_PEND, 0, "zero_pending");

        // Scoreboard round trip on register 5.
        tick();
        issue = 1; issue_addr = 5'd5;
        raddr1 = 5'd5;
        expect_val(K_HZ1, 0, "rt_hz_c0");
        expect_val(K_PEND, 0, "rt_pend_c0");
        tick();
        expect_val(K_HZ1, 1, "rt_hz_c1");
        expect_val(K_PEND, 1, "rt_pend_c1");
        tick();
        expect_val(K_HZ1, 1, "rt_hz_c2");
        tick();
        wr1 = 1; waddr1 = 5'd5; wdata1 = 32'hABCD;
        expect_val(K_HZ1, 0, "rt_hz_c3");
        expect_val(K_RD1, 32'hABCD, "rt_rd_c3");
        expect_val(K_PEND, 1, "rt_pend_c3");
        tick();
        expect_val(K_PEND, 0, "rt_pend_c4");
        expect_val(K_HZ1, 0, "rt_hz_c4");
        expect_val(K_RD1, 32'hABCD, "rt_rd_c4");

        // Set and clear of 9 in one cycle: bit stays busy, count unchanged.
        tick();
        issue = 1; issue_addr = 5'd9;
        raddr1 = 5'd9;
        tick();
        issue = 1; issue_addr = 5'd9;
        wr0 = 1; waddr0 = 5'd9; wdata0 = 32'h99;
        expect_val(K_PEND, 1, "setclr_pend_same");
        expect_val(K_HZ1, 0, "setclr_hz_same");
        expect_val(K_RD1, 32'h99, "setclr_bypass");
        tick();
        expect_val(K_HZ1, 1, "setclr_busy_kept");
        expect_val(K_PEND, 1, "setclr_pend_next");
        expect_val(K_RD1, 32'h99, "setclr_stored");

        // Both ports retire 9 together: count drops by exactly one.
        tick();
        wr0 = 1; waddr0 = 5'd9; wdata0 = 32'h97;
        wr1 = 1; waddr1 = 5'd9; wdata1 = 32'h98;
        expect_val(K_RD1, 32'h98, "dblclr_bypass");
        expect_val(K_HZ1, 0, "dblclr_hz");
        tick();
        expect_val(K_PEND, 0, "dblclr_pend");
        expect_val(K_HZ1, 0, "dblclr_hz_next");
        expect_val(K_RD1, 32'h98, "dblclr_stored");

        // Flush overrides a same-cycle issue; writes in that cycle still land.
        tick();
        issue = 1; issue_addr = 5'd3;
        tick();
        issue = 1; issue_addr = 5'd4;
        expect_val(K_PEND, 1, "fl_pend_1");
        tick();
        issue = 1; issue_addr = 5'd6;
        expect_val(K_PEND, 2, "fl_pend_2");
        tick();
        flush = 1; issue = 1; issue_addr = 5'd8;
        wr0 = 1; waddr0 = 5'd13; wdata0 = 32'h13;
        raddr1 = 5'd8; raddr2 = 5'd3;
        expect_val(K_PEND, 3, "fl_pend_3");
        expect_val(K_HZ1, 0, "fl_hz8_same");
        expect_val(K_HZ2, 1, "fl_hz3_same");
        tick();
        expect_val(K_PEND, 0, "fl_pend_after");
        expect_val(K_HZ1, 0, "fl_hz8_after");
        expect_val(K_HZ2, 0, "fl_hz3_after");
        tick();
        raddr1 = 5'd13;
        expect_val(K_RD1, 32'h13, "fl_write_kept");

        // Asynchronous reset mid-cycle with producers outstanding.
        tick();
        issue = 1; issue_addr = 5'd3;
        tick();
        issue = 1; issue_addr = 5'd4;
        raddr1 = 5'd7; raddr2 = 5'd3;
        expect_val(K_HZ2, 1, "pre_rst_hz2");
        expect_val(K_RD1, 32'h22, "pre_rst_rd1");
        expect_val(K_PEND, 1, "pre_rst_pend1");
        tick();
        expect_val(K_PEND, 2, "pre_rst_pend2");
        expect_val(K_HZ2, 1, "pre_rst_hz2b");
        tick();
        #2 rst_n = 1'b0;
        expect_val(K_RD1, 0, "arst_rd1");
        expect_val(K_RD2, 0, "arst_rd2");
        expect_val(K_HZ2, 0, "arst_hz2");
        expect_val(K_PEND, 0, "arst_pend");
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        expect_val(K_RD1, 0, "post_rst_rd1");
        expect_val(K_HZ2, 0, "post_rst_hz2");
        expect_val(K_PEND, 0, "post_rst_pend");

        tick();
        tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
